pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline advance/bubble/redirect controller for a 7-register in-order pipe.
// Latency: adv/bubble/redirect are combinational in the same cycle; state and counters update next edge.
// Backpressure: mem_busy freezes regs 0..4, hzd_stall freezes regs 0..3; a blocked mispredict is held pending.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   en                             global enable (low freezes everything)
//   hzd_stall, mem_busy            stall sources (EX operand, MEM completion)
//   br_mispred, br_target          branch mispredict and correct PC from EX
//   if_rdy                         fetch has a valid instruction
//   drain_req, stg_valid           drain request and valid bits of regs 1..6
//   adv, bubble                    per-register load enable / load-invalid
//   redir_valid, redir_pc          pc redirect this cycle and its target
//   state, drain_done              FSM state (RUN/REFILL/DRAIN/DRAINED), drained flag
//   stall_cnt, flush_cnt           saturating stall-cycle and redirect counters
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        hzd_stall,
  input  logic        mem_busy,
  input  logic        br_mispred,
  input  logic [31:0] br_target,
  input  logic        if_rdy,
  input  logic        drain_req,
  input  logic [5:0]  stg_valid,
  output logic [6:0]  adv,
  output logic [6:0]  bubble,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic [1:0]  state,
  output logic        drain_done,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REFILL  = 2'd1,
    DRAIN   = 2'd2,
    DRAINED = 2'd3
  } state_t;

  state_t      st;
  logic        pend_vld;
  logic [31:0] pend_pc;
  logic        stall;
  logic        do_redir;

  assign stall    = mem_busy | hzd_stall;
  // A redirect only happens on an enabled, unstalled cycle; otherwise it waits in pend_*.
  assign do_redir = en & ~stall & (br_mispred | pend_vld);
  assign state    = st;

  always_comb begin
    adv         = 7'h7F;
    bubble      = 7'h00;
    redir_valid = 1'b0;
    // A live mispredict is always newer than anything pending.
    redir_pc    = br_mispred ? br_target : pend_pc;
    drain_done  = ~rst & (st == DRAINED);
    if (rst) begin
      adv    = 7'h00;
      bubble = 7'h7E;
    end else if (!en) begin
      adv    = 7'h00;
    end else if (mem_busy) begin
      adv    = 7'h60;
      bubble = 7'h20;
    end else if (hzd_stall) begin
      adv    = 7'h70;
      bubble = 7'h10;
    end else if (br_mispred || pend_vld) begin
      // Squash the three younger stages behind the mispredicted branch.
      redir_valid = 1'b1;
      bubble      = 7'h0E;
    end else if (!if_rdy || st != RUN) begin
      adv    = 7'h7E;
      bubble = 7'h02;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= RUN;
      pend_vld  <= 1'b0;
      pend_pc   <= 32'h0;
      stall_cnt <= 16'h0;
      flush_cnt <= 16'h0;
    end else if (en) begin
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (do_redir && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;

      if (stall && br_mispred) begin
        pend_vld <= 1'b1;
        pend_pc  <= br_target;
      end else if (do_redir) begin
        pend_vld <= 1'b0;
      end

      case (st)
        RUN: begin
          if (do_redir)       st <= REFILL;
          else if (drain_req) st <= DRAIN;
        end
        REFILL: begin
          if (do_redir)                st <= REFILL;
          else if (if_rdy && !stall)   st <= RUN;
        end
        DRAIN: begin
          if (!drain_req)              st <= RUN;
          else if (stg_valid == 6'h0)  st <= DRAINED;
        end
        DRAINED: begin
          if (!drain_req)              st <= RUN;
        end
        default: st <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, hzd_stall, mem_busy, br_mispred, if_rdy, drain_req;
  logic [31:0] br_target;
  logic [5:0]  stg_valid;
  logic [6:0]  adv, bubble;
  logic        redir_valid, drain_done;
  logic [31:0] redir_pc;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .hzd_stall(hzd_stall), .mem_busy(mem_busy),
    .br_mispred(br_mispred), .br_target(br_target), .if_rdy(if_rdy),
    .drain_req(drain_req), .stg_valid(stg_valid), .adv(adv), .bubble(bubble),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .state(state),
    .drain_done(drain_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rst = 0; en = 1; hzd_stall = 0; mem_busy = 0; br_mispred = 0;
    br_target = 32'h0; if_rdy = 1; drain_req = 0; stg_valid = 6'h0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic       rst, en, mb, hz, br, fr;
    logic [6:0] e_adv, e_bub;
    logic       e_rv;
  } vec_t;

  vec_t vt[8];

  // Reference model state: plain integers, updated from the rule list.
  int          m_st, m_scnt, m_fcnt;
  bit          m_pend;
  logic [31:0] m_tgt;

  initial begin
    idle();
    rst = 1;
    #1;
    chk("reset_adv",    adv,    7'h00);
    chk("reset_bubble", bubble, 7'h7E);
    chk("reset_done",   drain_done, 1'b0);
    tick();
    chk("reset_state", state, 2'd0);
    chk("reset_scnt",  stall_cnt, 16'h0);
    chk("reset_fcnt",  flush_cnt, 16'h0);

    // ---------------- table vectors, each from a clean RUN state ----------------
    vt[0] = '{0,1,0,0,0,1, 7'h7F, 7'h00, 0};
    vt[1] = '{0,0,1,1,1,1, 7'h00, 7'h00, 0};
    vt[2] = '{0,1,1,0,0,1, 7'h60, 7'h20, 0};
    vt[3] = '{0,1,1,1,1,1, 7'h60, 7'h20, 0};
    vt[4] = '{0,1,0,1,1,0, 7'h70, 7'h10, 0};
    vt[5] = '{0,1,0,0,1,0, 7'h7F, 7'h0E, 1};
    vt[6] = '{0,1,0,0,0,0, 7'h7E, 7'h02, 0};
    vt[7] = '{1,1,1,1,1,1, 7'h00, 7'h7E, 0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      rst = vt[i].rst; en = vt[i].en; mem_busy = vt[i].mb; hzd_stall = vt[i].hz;
      br_mispred = vt[i].br; if_rdy = vt[i].fr; br_target = 32'hA000_0000 + i;
      #1;
      chk($sformatf("vec%0d_adv", i), adv, vt[i].e_adv);
      chk($sformatf("vec%0d_bub", i), bubble, vt[i].e_bub);
      chk($sformatf("vec%0d_rv", i),  redir_valid, vt[i].e_rv);
    end

    // ---------------- three hazard-stall cycles ----------------
    do_reset();
    hzd_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hz3_adv", adv, 7'h70);
      chk("hz3_bub4", bubble[4], 1'b1);
      tick();
    end
    hzd_stall = 0;
    chk("hz3_scnt", stall_cnt, 16'd3);

    // ---------------- mispredict deferred behind mem_busy ----------------
    do_reset();
    mem_busy = 1; br_mispred = 1; br_target = 32'h0000_1000;
    #1;
    chk("defer_rv_blocked", redir_valid, 1'b0);
    tick();
    mem_busy = 0; br_mispred = 0; br_target = 32'hDEAD_BEEF; if_rdy = 0;
    #1;
    chk("defer_rv", redir_valid, 1'b1);
    chk("defer_pc", redir_pc, 32'h0000_1000);
    tick();
    chk("defer_fcnt", flush_cnt, 16'd1);
    chk("defer_refill", state, 2'd1);
    #1;
    chk("refill_rv_clear", redir_valid, 1'b0);
    chk("refill_adv", adv, 7'h7E);
    tick();
    chk("refill_hold", state, 2'd1);
    if_rdy = 1;
    tick();
    chk("refill_exit", state, 2'd0);

    // ---------------- drain sequence ----------------
    do_reset();
    drain_req = 1; stg_valid = 6'h3F;
    tick();
    chk("drain_enter", state, 2'd2);
    for (int i = 5; i >= 0; i--) begin
      logic [5:0] full;
      full = 6'h3F;
      stg_valid = full >> (6 - i);
      #1;
      chk("drain_adv0", adv[0], 1'b0);
      tick();
    end
    chk("drained_state", state, 2'd3);
    #1;
    chk("drained_done", drain_done, 1'b1);
    chk("drained_adv0", adv[0], 1'b0);
    drain_req = 0;
    tick();
    chk("drained_exit", state, 2'd0);
    chk("drained_done_clr", drain_done, 1'b0);

    // ---------------- drain abandoned ----------------
    drain_req = 1; stg_valid = 6'h01;
    tick();
    drain_req = 0;
    tick();
    chk("drain_abort", state, 2'd0);

    // ---------------- reset while pending in REFILL ----------------
    do_reset();
    hzd_stall = 1; br_mispred = 1; br_target = 32'h2000;
    tick();
    hzd_stall = 0; br_mispred = 0; if_rdy = 0;
    tick();
    mem_busy = 1; br_mispred = 1; br_target = 32'h3000;
    tick();
    chk("rstp_refill", state, 2'd1);
    mem_busy = 0; br_mispred = 0;
    rst = 1;
    #1;
    chk("rstp_adv", adv, 7'h00);
    chk("rstp_bub", bubble, 7'h7E);
    tick();
    rst = 0; if_rdy = 1;
    chk("rstp_state", state, 2'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rstp_no_redir", redir_valid, 1'b0);
      tick();
    end
    chk("rstp_fcnt", flush_cnt, 16'd0);

    // ---------------- stall counter saturation ----------------
    do_reset();
    hzd_stall = 1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    en = 0;
    tick();
    chk("en0_hold", stall_cnt, 16'hFFFF);

    // ---------------- randomized run against the reference model ----------------
    do_reset();
    m_st = 0; m_pend = 0; m_tgt = 0; m_scnt = 0; m_fcnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [6:0] e_adv, e_bub;
      logic       e_rv;
      logic [31:0] e_pc;
      bit stl, redir;
      rst        = ($urandom_range(0, 59) == 0);
      en         = ($urandom_range(0, 9) != 0);
      mem_busy   = ($urandom_range(0, 7) == 0);
      hzd_stall  = ($urandom_range(0, 5) == 0);
      br_mispred = ($urandom_range(0, 7) == 0);
      br_target  = $urandom;
      if_rdy     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) drain_req = ~drain_req;
      stg_valid  = ($urandom_range(0, 3) == 0) ? 6'h0 : 6'($urandom);
      #1;
      e_rv = 0;
      e_pc = br_mispred ? br_target : m_tgt;
      if (rst)                         begin e_adv = 7'h00; e_bub = 7'h7E; end
      else if (!en)                    begin e_adv = 7'h00; e_bub = 7'h00; end
      else if (mem_busy)               begin e_adv = 7'h60; e_bub = 7'h20; end
      else if (hzd_stall)              begin e_adv = 7'h70; e_bub = 7'h10; end
      else if (br_mispred || m_pend)   begin e_adv = 7'h7F; e_bub = 7'h0E; e_rv = 1; end
      else if (!if_rdy || m_st != 0)   begin e_adv = 7'h7E; e_bub = 7'h02; end
      else                             begin e_adv = 7'h7F; e_bub = 7'h00; end
      chk("rnd_adv", adv, e_adv);
      chk("rnd_bub", bubble, e_bub);
      chk("rnd_rv", redir_valid, e_rv);
      if (e_rv) chk("rnd_pc", redir_pc, e_pc);
      chk("rnd_done", drain_done, (!rst && m_st == 3));
      @(posedge clk);
      #1;
      if (rst) begin
        m_st = 0; m_pend = 0; m_scnt = 0; m_fcnt = 0;
      end else if (en) begin
        stl   = mem_busy || hzd_stall;
        redir = !stl && (br_mispred || m_pend);
        if (stl) m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
        if (stl && br_mispred) begin m_pend = 1; m_tgt = br_target; end
        if (redir) begin m_pend = 0; m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : 65535; end
        case (m_st)
          0: m_st = redir ? 1 : (drain_req ? 2 : 0);
          1: m_st = redir ? 1 : ((if_rdy && !stl) ? 0 : 1);
          2: m_st = !drain_req ? 0 : ((stg_valid == 0) ? 3 : 2);
          default: m_st = drain_req ? 3 : 0;
        endcase
      end
      chk("rnd_state", state, m_st);
      chk("rnd_scnt", stall_cnt, m_scnt);
      chk("rnd_fcnt", flush_cnt, m_fcnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
